// File: rtl/chroma_pkg.sv
// Shared types and constants for the chroma subcarrier modulator.
package chroma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    DELAY = 2'd2,
    BURST = 2'd3
  } state_t;

  localparam int DEF_BURST_DELAY = 5;
  localparam int DEF_BURST_LEN   = 10;
  localparam int DEF_BURST_AMP   = 40;

  // Subcarrier cycle counter width; covers the 1..15 delay/length range
  localparam int CNT_W = 4;

  localparam logic MODE_PAL  = 1'b0;
  localparam logic MODE_NTSC = 1'b1;

endpackage

// File: rtl/colorclk_tick.sv
// Rising-edge detector on the 4x colour clock plus the 2-bit quarter-phase counter.
module colorclk_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkcolor4x,
  output logic       tick,
  output logic       wrap,
  output logic [1:0] phase
);

  logic clkcolor4x_d;
  logic armed;

  // armed stays low if the colour clock is already high as reset releases, so a level is never taken for an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clkcolor4x_d <= 1'b0;
      armed        <= ~clkcolor4x;
      phase        <= 2'd0;
    end else begin
      clkcolor4x_d <= clkcolor4x;
      if (!clkcolor4x) begin
        armed <= 1'b1;
      end
      if (tick) begin
        phase <= phase + 2'd1;
      end
    end
  end

  assign tick = clkcolor4x & ~clkcolor4x_d & armed;
  assign wrap = tick & (phase == 2'd3);

endmodule

// File: rtl/chroma_subcarrier_mod.sv
// Quadrature chroma modulator: U/V onto a 4x-sampled subcarrier, with PAL V-switch
// and colour burst inserted a fixed number of subcarrier cycles after HSYNC.
module chroma_subcarrier_mod
  import chroma_pkg::*;
#(
  parameter int CW          = 8,
  parameter int BURST_DELAY = DEF_BURST_DELAY,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int BURST_AMP   = DEF_BURST_AMP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 clkcolor4x,
  input  logic                 hsync,
  input  logic                 blank,
  input  logic signed [CW-1:0] u,
  input  logic signed [CW-1:0] v,
  output logic signed [CW:0]   chroma,
  output logic                 burst_en,
  output logic [1:0]           phase,
  output logic                 vswitch
);

  localparam logic signed [CW:0] AMP = (CW+1)'(BURST_AMP);

  logic             tick;
  logic             wrap;
  logic             hsync_d;
  logic             hs_rise;
  logic             hs_fall;
  logic             mode_l;
  state_t           state;
  state_t           state_next;
  state_t           out_state;
  logic [CNT_W-1:0] cyc_cnt;
  logic signed [CW:0] u_ext;
  logic signed [CW:0] v_ext;
  logic signed [CW:0] sv;
  logic signed [CW:0] chroma_next;
  logic             burst_next;

  colorclk_tick u_tick (
    .clk        (clk),
    .rst        (rst),
    .clkcolor4x (clkcolor4x),
    .tick       (tick),
    .wrap       (wrap),
    .phase      (phase)
  );

  assign hs_rise = hsync & ~hsync_d;
  assign hs_fall = ~hsync & hsync_d;

  // Standard is only switched at line start so a mid-line mode change cannot corrupt a burst
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_d <= 1'b0;
      mode_l  <= MODE_PAL;
      vswitch <= 1'b0;
    end else begin
      hsync_d <= hsync;
      if (hs_rise) begin
        mode_l  <= mode;
        vswitch <= (mode == MODE_PAL) ? ~vswitch : 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      SYNC:    if (hs_fall) state_next = DELAY;
      DELAY:   if (wrap && cyc_cnt == CNT_W'(BURST_DELAY - 1)) state_next = BURST;
      BURST:   if (wrap && cyc_cnt == CNT_W'(BURST_LEN - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (hs_rise) begin
      state_next = SYNC;
    end
  end

  // Counts subcarrier wraps within DELAY/BURST; restarts on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if (hs_rise || state_next != state) begin
      cyc_cnt <= '0;
    end else if (wrap && (state == DELAY || state == BURST)) begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  assign u_ext = {u[CW-1], u};
  assign v_ext = {v[CW-1], v};
  assign sv    = vswitch ? -v_ext : v_ext;

  // A sync edge landing on a tick already counts as SYNC so that sample is blanked
  always_comb begin
    out_state   = hs_rise ? SYNC : state;
    chroma_next = '0;
    burst_next  = (out_state == BURST);
    case (out_state)
      IDLE: begin
        if (!blank) begin
          case (phase)
            2'd0:    chroma_next = u_ext;
            2'd1:    chroma_next = sv;
            2'd2:    chroma_next = -u_ext;
            default: chroma_next = -sv;
          endcase
        end
      end
      BURST: begin
        if (mode_l == MODE_NTSC) begin
          case (phase)
            2'd0:    chroma_next = -AMP;
            2'd2:    chroma_next = AMP;
            default: chroma_next = '0;
          endcase
        end else begin
          case (phase)
            2'd0:    chroma_next = -AMP;
            2'd1:    chroma_next = vswitch ? -AMP : AMP;
            2'd2:    chroma_next = AMP;
            default: chroma_next = vswitch ? AMP : -AMP;
          endcase
        end
      end
      default: chroma_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chroma   <= '0;
      burst_en <= 1'b0;
    end else if (tick) begin
      chroma   <= chroma_next;
      burst_en <= burst_next;
    end
  end

endmodule

// File: tb/tb_chroma_subcarrier_mod.sv
// Directed bench for chroma_subcarrier_mod; expected samples are queued at each colour-clock edge and checked by a monitor.
module tb_chroma_subcarrier_mod;
  import chroma_pkg::*;

  typedef struct {
    int               due;
    logic signed [8:0] chroma;
    logic             burst_en;
    logic [1:0]       phase;
    logic             vswitch;
  } exp_t;

  localparam logic signed [8:0] VIDEO_VS0 [4]     = '{9'sd20, 9'sd10, -9'sd20, -9'sd10};
  localparam logic signed [8:0] VIDEO_VS1 [4]     = '{9'sd20, -9'sd10, -9'sd20, 9'sd10};
  localparam logic signed [8:0] NTSC_BURST [4]    = '{-9'sd40, 9'sd0, 9'sd40, 9'sd0};
  localparam logic signed [8:0] PAL_BURST_VS0 [4] = '{-9'sd40, 9'sd40, 9'sd40, -9'sd40};
  localparam logic signed [8:0] PAL_BURST_VS1 [4] = '{-9'sd40, -9'sd40, 9'sd40, 9'sd40};
  localparam logic signed [8:0] EXTREME_VS1 [4]   = '{-9'sd128, -9'sd5, 9'sd128, 9'sd5};

  logic              clk;
  logic              rst;
  logic              mode;
  logic              clkcolor4x;
  logic              hsync;
  logic              blank;
  logic signed [7:0] u;
  logic signed [7:0] v;
  logic signed [8:0] chroma;
  logic              burst_en;
  logic [1:0]        phase;
  logic              vswitch;

  int         cyc = 0;
  int         n_compared = 0;
  int         n_mismatched = 0;
  exp_t       exp_q [$];
  string      name_q [$];
  logic [1:0] exp_phase;
  logic       exp_vs;

  chroma_subcarrier_mod #(
    .CW          (8),
    .BURST_DELAY (5),
    .BURST_LEN   (10),
    .BURST_AMP   (40)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .clkcolor4x (clkcolor4x),
    .hsync      (hsync),
    .blank      (blank),
    .u          (u),
    .v          (v),
    .chroma     (chroma),
    .burst_en   (burst_en),
    .phase      (phase),
    .vswitch    (vswitch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_exp(input int due, input logic signed [8:0] c, input logic b,
                                   input logic [1:0] ph, input logic vs, input string nm);
    exp_t e;
    e.due      = due;
    e.chroma   = c;
    e.burst_en = b;
    e.phase    = ph;
    e.vswitch  = vs;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endfunction

  task automatic checkOutput(input exp_t e, input string nm);
    n_compared++;
    if (chroma !== e.chroma || burst_en !== e.burst_en || phase !== e.phase || vswitch !== e.vswitch) begin
      n_mismatched++;
      $display("[TB] FAIL %s @cyc %0d: got chroma=%0d burst_en=%0b phase=%0d vswitch=%0b, want chroma=%0d burst_en=%0b phase=%0d vswitch=%0b",
               nm, cyc, chroma, burst_en, phase, vswitch, e.chroma, e.burst_en, e.phase, e.vswitch);
    end
  endtask

  // Monitor: checks every queued expectation on the falling edge of its due cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      checkOutput(exp_q.pop_front(), name_q.pop_front());
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One colour-clock period (4 high, 4 low); the tick's result is due one clock later
  task automatic applyStimulus(input logic signed [8:0] exp_c, input logic exp_b,
                               input bit with_hs, input string nm);
    clkcolor4x = 1'b1;
    if (with_hs) hsync = 1'b1;
    exp_phase = exp_phase + 2'd1;
    push_exp(cyc + 1, exp_c, exp_b, exp_phase, exp_vs, nm);
    wait_cycles(4);
    clkcolor4x = 1'b0;
    wait_cycles(4);
  endtask

  task automatic hsync_pulse();
    hsync = 1'b1;
    wait_cycles(3);
    hsync = 1'b0;
    wait_cycles(2);
  endtask

  task automatic run_line(input logic md, input logic vs_new);
    logic signed [8:0] b;
    mode = md;
    hsync_pulse();
    exp_vs = vs_new;
    for (int i = 0; i < 20; i++) applyStimulus(9'sd0, 1'b0, 1'b0, "delay");
    for (int i = 0; i < 40; i++) begin
      if (md == MODE_NTSC) b = NTSC_BURST[i % 4];
      else if (vs_new)     b = PAL_BURST_VS1[i % 4];
      else                 b = PAL_BURST_VS0[i % 4];
      applyStimulus(b, 1'b1, 1'b0, "burst");
    end
    for (int i = 0; i < 4; i++)
      applyStimulus(vs_new ? VIDEO_VS1[i] : VIDEO_VS0[i], 1'b0, 1'b0, "line video");
  endtask

  initial begin
    rst        = 1'b1;
    mode       = MODE_NTSC;
    clkcolor4x = 1'b0;
    hsync      = 1'b0;
    blank      = 1'b0;
    u          = 8'sd20;
    v          = 8'sd10;
    exp_phase  = 2'd0;
    exp_vs     = 1'b0;

    wait_cycles(3);
    rst = 1'b0;
    push_exp(cyc, 9'sd0, 1'b0, 2'd0, 1'b0, "reset state");
    wait_cycles(2);

    for (int i = 0; i < 8; i++) applyStimulus(VIDEO_VS0[i % 4], 1'b0, 1'b0, "ntsc video");

    $display("[TB] PAL lines with V-switch");
    run_line(MODE_PAL, 1'b1);
    run_line(MODE_PAL, 1'b0);
    run_line(MODE_PAL, 1'b1);

    $display("[TB] extreme U and blanking");
    u = 8'h80;
    v = 8'sd5;
    for (int i = 0; i < 4; i++) applyStimulus(EXTREME_VS1[i], 1'b0, 1'b0, "u=-128");
    u = 8'sd20;
    v = 8'sd10;
    blank = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(9'sd0, 1'b0, 1'b0, "blanked");
    blank = 1'b0;

    $display("[TB] burst abort, mid-line mode change, reset in DELAY");
    mode = MODE_NTSC;
    hsync_pulse();
    exp_vs = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(9'sd0, 1'b0, 1'b0, "ntsc delay");
    for (int i = 0; i < 8; i++) begin
      if (i == 4) mode = MODE_PAL;
      applyStimulus(NTSC_BURST[i % 4], 1'b1, 1'b0, "ntsc burst");
    end
    exp_vs = 1'b1;
    applyStimulus(9'sd0, 1'b0, 1'b1, "abort tick");
    hsync = 1'b0;
    wait_cycles(2);
    applyStimulus(9'sd0, 1'b0, 1'b0, "delay after abort");

    clkcolor4x = 1'b1;
    exp_phase = exp_phase + 2'd1;
    push_exp(cyc + 1, 9'sd0, 1'b0, exp_phase, exp_vs, "delay tick before rst");
    wait_cycles(1);
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    exp_phase = 2'd0;
    exp_vs = 1'b0;
    push_exp(cyc, 9'sd0, 1'b0, 2'd0, 1'b0, "outputs after mid-line rst");
    wait_cycles(2);
    push_exp(cyc, 9'sd0, 1'b0, 2'd0, 1'b0, "no tick while clkcolor4x high");
    wait_cycles(1);
    clkcolor4x = 1'b0;
    wait_cycles(4);
    for (int i = 0; i < 4; i++) applyStimulus(VIDEO_VS0[i], 1'b0, 1'b0, "video after rst");

    wait_cycles(4);
    while (exp_q.size() > 0) begin
      n_mismatched++;
      $display("[TB] FAIL unchecked %s: due cycle %0d never reached, now %0d", name_q.pop_front(), exp_q.pop_front().due, cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
